// File: rtl/handshake_tx_pkg.sv
// Shared types and defaults for the handshake_tx transmitter.
package handshake_tx_pkg;

    localparam int unsigned DEF_WIDTH = 12;
    localparam int unsigned DEF_DEPTH = 4;

    // Four-phase transmit sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2
    } state_t;

    // Occupancy counter width able to hold 0..depth inclusive
    function automatic int unsigned level_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/handshake_tx_if.sv
// Core-side FIFO input plus receiver-side 4-phase request/acknowledge bundle.
interface handshake_tx_if #(
    parameter int unsigned WIDTH = handshake_tx_pkg::DEF_WIDTH,
    parameter int unsigned DEPTH = handshake_tx_pkg::DEF_DEPTH
);
    localparam int unsigned LW = handshake_tx_pkg::level_width(DEPTH);

    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic [LW-1:0]    level;
    logic             req;
    logic [WIDTH-1:0] dout;
    logic             ack;

    // Transmitter side
    modport master (
        input  din, din_valid, ack,
        output din_ready, level, req, dout
    );

    // Core and receiver side
    modport slave (
        output din, din_valid, ack,
        input  din_ready, level, req, dout
    );

endinterface

// File: rtl/handshake_tx_sync_fifo.sv
// Single-clock show-ahead FIFO; full/empty/count are registered.
module sync_fifo
    import handshake_tx_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic                          pop,
    input  logic [WIDTH-1:0]              wdata,
    output logic [WIDTH-1:0]              rdata,
    output logic                          full,
    output logic                          empty,
    output logic [level_width(DEPTH)-1:0] count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = level_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_nxt;
    logic             do_push;
    logic             do_pop;

    // Guard against overflow/underflow regardless of caller
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Next occupancy; simultaneous push and pop leave it unchanged
    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + CW'(1);
        end else if (do_pop && !do_push) begin
            count_nxt = count - CW'(1);
        end
    end

    // Storage array, no reset needed since reads are gated by empty
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/handshake_tx.sv
// FIFO-buffered 4-phase handshake transmitter.
// Define HANDSHAKE_TX_ACK_SYNC_EN to pass ack through a 2-flop synchronizer.
module handshake_tx
    import handshake_tx_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic           clk,
    input  logic           rst,
    handshake_tx_if.master bus
);
    localparam int unsigned CW = level_width(DEPTH);

    state_t           state;
    logic             ack_s;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] rdata;
    logic [CW-1:0]    count;

`ifdef HANDSHAKE_TX_ACK_SYNC_EN
    logic [1:0] ack_sync;

    // Two-flop synchronizer for an ack from another clock domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[0], bus.ack};
        end
    end

    assign ack_s = ack_sync[1];
`else
    assign ack_s = bus.ack;
`endif

    // A launch needs a word and a low ack; a high ack in IDLE is stale
    assign push = bus.din_valid && !full;
    assign pop  = (state == IDLE) && !empty && !ack_s;

    assign bus.din_ready = !full;
    assign bus.level     = count;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (bus.din),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Handshake sequencer; dout only updates on a pop so it stays stable while req is high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bus.req  <= 1'b0;
            bus.dout <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        bus.dout <= rdata;
                        bus.req  <= 1'b1;
                        state    <= REQ_HI;
                    end
                end
                REQ_HI: begin
                    if (ack_s) begin
                        bus.req <= 1'b0;
                        state   <= REQ_LO;
                    end
                end
                REQ_LO: begin
                    if (!ack_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    bus.req <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_handshake_tx.sv
// Directed testbench for handshake_tx; works with or without HANDSHAKE_TX_ACK_SYNC_EN.
module tb_handshake_tx;
    import handshake_tx_pkg::*;

`ifdef HANDSHAKE_TX_ACK_SYNC_EN
    localparam int ACK_LAT = 2;
`else
    localparam int ACK_LAT = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    handshake_tx_if #(.WIDTH(12), .DEPTH(4)) bus ();

    handshake_tx #(.WIDTH(12), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled 1 after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Receiver model: wait for req, capture, ack after delay, release ack once req drops
    task automatic recv_word(input int delay, output logic [11:0] w, output bit ok);
        int t;
        ok = 1'b1;
        t  = 0;
        while (bus.req !== 1'b1 && t < 60) begin
            tick();
            t++;
        end
        if (bus.req !== 1'b1) ok = 1'b0;
        w = bus.dout;
        repeat (delay) tick();
        bus.ack = 1'b1;
        t = 0;
        while (bus.req !== 1'b0 && t < 60) begin
            tick();
            t++;
        end
        if (bus.req !== 1'b0) ok = 1'b0;
        bus.ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.ack = 1'b0;
        bus.din = '0;
        bus.din_valid = 1'b0;
        repeat (2) tick();
        n_cmp++; if (bus.req !== 1'b0) begin n_bad++; $display("FAIL reset_req got %0b want 0", bus.req); end
        n_cmp++; if (bus.dout !== 12'h000) begin n_bad++; $display("FAIL reset_dout got %h want 000", bus.dout); end
        n_cmp++; if (bus.level !== 3'd0) begin n_bad++; $display("FAIL reset_level got %0d want 0", bus.level); end
        n_cmp++; if (bus.din_ready !== 1'b1) begin n_bad++; $display("FAIL reset_din_ready got %0b want 1", bus.din_ready); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_word();
        int cnt;
        bus.din = 12'hABC;
        bus.din_valid = 1'b1;
        tick();
        bus.din_valid = 1'b0;
        n_cmp++; if (bus.level !== 3'd1 || bus.req !== 1'b0) begin n_bad++; $display("FAIL single_written got level=%0d req=%0b want level=1 req=0", bus.level, bus.req); end
        tick();
        n_cmp++; if (bus.req !== 1'b1 || bus.dout !== 12'hABC) begin n_bad++; $display("FAIL single_launch got req=%0b dout=%h want req=1 dout=abc", bus.req, bus.dout); end
        n_cmp++; if (bus.level !== 3'd0) begin n_bad++; $display("FAIL single_popped got level=%0d want 0", bus.level); end
        bus.ack = 1'b1;
        cnt = 0;
        while (bus.req === 1'b1 && cnt < 20) begin tick(); cnt++; end
        n_cmp++; if (cnt != 1 + ACK_LAT) begin n_bad++; $display("FAIL single_req_fall got %0d cycles want %0d", cnt, 1 + ACK_LAT); end
        n_cmp++; if (bus.dout !== 12'hABC) begin n_bad++; $display("FAIL single_dout_hold got %h want abc", bus.dout); end
        bus.ack = 1'b0;
        cnt = 0;
        while (dut.state !== IDLE && cnt < 20) begin tick(); cnt++; end
        n_cmp++; if (cnt != 1 + ACK_LAT) begin n_bad++; $display("FAIL single_idle_return got %0d cycles want %0d", cnt, 1 + ACK_LAT); end
    endtask

    task automatic test_fill();
        logic [11:0] w;
        bit          ok;
        bus.ack = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            bus.din = 12'(i);
            bus.din_valid = 1'b1;
            tick();
            if (i == 2) begin
                n_cmp++; if (bus.req !== 1'b1 || bus.dout !== 12'h001) begin n_bad++; $display("FAIL fill_first_pop got req=%0b dout=%h want req=1 dout=001", bus.req, bus.dout); end
            end
            if (i == 5) begin
                n_cmp++; if (bus.level !== 3'd4 || bus.din_ready !== 1'b0) begin n_bad++; $display("FAIL fill_full got level=%0d din_ready=%0b want level=4 din_ready=0", bus.level, bus.din_ready); end
            end
            if (i == 6) begin
                n_cmp++; if (bus.level !== 3'd4) begin n_bad++; $display("FAIL fill_refused got level=%0d want 4", bus.level); end
            end
        end
        bus.din_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            recv_word(0, w, ok);
            n_cmp++; if (!ok || w !== 12'(k)) begin n_bad++; $display("FAIL fill_drain_%0d got %h ok=%0b want %h", k, w, ok, 12'(k)); end
        end
        repeat (6) tick();
        n_cmp++; if (bus.req !== 1'b0 || bus.level !== 3'd0) begin n_bad++; $display("FAIL fill_no_sixth got req=%0b level=%0d want req=0 level=0", bus.req, bus.level); end
    endtask

    task automatic test_ordering();
        fork
            begin
                int t;
                for (int i = 0; i < 16; i++) begin
                    bus.din = 12'(i);
                    bus.din_valid = 1'b1;
                    t = 0;
                    while (bus.din_ready !== 1'b1 && t < 200) begin tick(); t++; end
                    tick();
                end
                bus.din_valid = 1'b0;
            end
            begin
                logic [11:0] w;
                bit          ok;
                for (int j = 0; j < 16; j++) begin
                    recv_word(int'($urandom_range(0, 3)), w, ok);
                    n_cmp++; if (!ok || w !== 12'(j)) begin n_bad++; $display("FAIL order_%0d got %h ok=%0b want %h", j, w, ok, 12'(j)); end
                end
            end
        join
        repeat (6) tick();
        n_cmp++; if (bus.req !== 1'b0 || bus.level !== 3'd0) begin n_bad++; $display("FAIL order_no_extra got req=%0b level=%0d want req=0 level=0", bus.req, bus.level); end
    endtask

    task automatic test_stale_ack();
        int cnt;
        bit seen;
        rst = 1'b1;
        bus.ack = 1'b1;
        bus.din_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        bus.din = 12'h123;
        bus.din_valid = 1'b1;
        tick();
        bus.din_valid = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            tick();
            if (bus.req !== 1'b0) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL stale_blocked got req high want req low"); end
        n_cmp++; if (bus.level !== 3'd1) begin n_bad++; $display("FAIL stale_pending got level=%0d want 1", bus.level); end
        bus.ack = 1'b0;
        cnt = 0;
        while (bus.req !== 1'b1 && cnt < 20) begin tick(); cnt++; end
        n_cmp++; if (cnt != 1 + ACK_LAT) begin n_bad++; $display("FAIL stale_launch got %0d cycles want %0d", cnt, 1 + ACK_LAT); end
        n_cmp++; if (bus.dout !== 12'h123) begin n_bad++; $display("FAIL stale_dout got %h want 123", bus.dout); end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        bus.ack = 1'b0;
        bus.din_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.din = 12'h0A0 + 12'(i);
            bus.din_valid = 1'b1;
            tick();
        end
        bus.din_valid = 1'b0;
        n_cmp++; if (bus.req !== 1'b1 || bus.level !== 3'd2) begin n_bad++; $display("FAIL mid_setup got req=%0b level=%0d want req=1 level=2", bus.req, bus.level); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.req !== 1'b0) begin n_bad++; $display("FAIL mid_req got %0b want 0", bus.req); end
        n_cmp++; if (bus.level !== 3'd0) begin n_bad++; $display("FAIL mid_level got %0d want 0", bus.level); end
        n_cmp++; if (bus.din_ready !== 1'b1 || bus.dout !== 12'h000) begin n_bad++; $display("FAIL mid_ready_dout got ready=%0b dout=%h want ready=1 dout=000", bus.din_ready, bus.dout); end
        tick();
        rst = 1'b0;
        repeat (6) tick();
        n_cmp++; if (bus.req !== 1'b0 || bus.level !== 3'd0) begin n_bad++; $display("FAIL mid_no_retx got req=%0b level=%0d want req=0 level=0", bus.req, bus.level); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_fill();
        test_ordering();
        test_stale_ack();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard stop in case a handshake never completes
    initial begin
        #200000;
        $display("FAIL watchdog timeout got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule
